// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - free-running raster counters with registered sync, blank and frame strobes
module vga_timing_gen #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29
) (
    input  logic        pclk,
    input  logic        rst_n,
    output logic [11:0] hcount,
    output logic        hsync,
    output logic        hblnk,
    output logic [11:0] vcount,
    output logic        vsync,
    output logic        vblnk,
    output logic        frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_size_check
            $error("vga_timing_gen: line or frame total exceeds 12-bit counter range");
        end
    endgenerate

    localparam logic [11:0] H_LAST       = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_BLANK_FROM = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_FROM  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_TO    = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0] V_LAST       = 12'(V_TOTAL - 1);
    localparam logic [11:0] V_BLANK_FROM = 12'(V_ACTIVE);
    localparam logic [11:0] V_SYNC_FROM  = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYNC_TO    = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic        h_wrap;
    logic        v_wrap;
    logic [11:0] h_next;
    logic [11:0] v_next;

    always_comb begin
        h_wrap = (hcount == H_LAST);
        v_wrap = (vcount == V_LAST);
        h_next = h_wrap ? 12'd0 : hcount + 12'd1;
        v_next = vcount;
        if (h_wrap) begin
            v_next = v_wrap ? 12'd0 : vcount + 12'd1;
        end
    end

    // Flags decode the next count so they land in the same register stage as the counters.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            hcount    <= 12'd0;
            vcount    <= 12'd0;
            hsync     <= 1'b0;
            hblnk     <= 1'b0;
            vsync     <= 1'b0;
            vblnk     <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            hcount    <= h_next;
            vcount    <= v_next;
            hblnk     <= (h_next >= H_BLANK_FROM);
            hsync     <= (h_next >= H_SYNC_FROM) && (h_next <= H_SYNC_TO);
            vblnk     <= (v_next >= V_BLANK_FROM);
            vsync     <= (v_next >= V_SYNC_FROM) && (v_next <= V_SYNC_TO);
            frame_end <= (h_next == H_LAST) && (v_next == V_LAST);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized-reset bench checking the raster generator against a position model
module tb_vga_timing_gen;

    localparam int HA = 16, HF = 3, HS = 5, HB = 6;
    localparam int VA = 12, VF = 2, VS = 3, VB = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] hcount, vcount;
    logic        hsync, hblnk, vsync, vblnk, frame_end;

    int     tests = 0;
    int     fails = 0;
    int     pos = 0;
    bit     model_valid = 1'b0;
    bit     rst_at_edge = 1'b0;
    int     since_rel = 0;
    longint cyc = 0;

    bit     end_req = 1'b0;
    bit     end_done = 1'b0;
    int     hs_run = 0;
    int     vs_cnt = 0;
    int     fe_since_rst = 0;
    longint last_fe = -1;

    int          eh, ev;
    logic [28:0] exp_vec, act_vec;

    always #5 pclk = ~pclk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .pclk(pclk),
        .rst_n(rst_n),
        .hcount(hcount),
        .hsync(hsync),
        .hblnk(hblnk),
        .vcount(vcount),
        .vsync(vsync),
        .vblnk(vblnk),
        .frame_end(frame_end)
    );

    // Model: linear pixel position within the frame since the last reset edge.
    always @(posedge pclk) begin
        cyc++;
        rst_at_edge = !rst_n;
        if (!rst_n) begin
            pos = 0;
            since_rel = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            pos = (pos + 1) % FRAME;
            since_rel++;
        end
    end

    always @(negedge pclk) begin
        if (model_valid) begin
            eh = pos % HT;
            ev = pos / HT;
            exp_vec = {12'(eh), 12'(ev),
                       (eh >= HA + HF) && (eh < HA + HF + HS), eh >= HA,
                       (ev >= VA + VF) && (ev < VA + VF + VS), ev >= VA,
                       pos == FRAME - 1};
            act_vec = {hcount, vcount, hsync, hblnk, vsync, vblnk, frame_end};
            tests++;
            if (act_vec !== exp_vec) begin
                fails++;
                $display("FAIL model pos=%0d actual h=%0d v=%0d hs,hb,vs,vb,fe=%b required h=%0d v=%0d hs,hb,vs,vb,fe=%b",
                         pos, hcount, vcount, act_vec[4:0], eh, ev, exp_vec[4:0]);
            end

            tests++;
            if (!((!hsync || hblnk) && (!vsync || vblnk) && hcount < HT && vcount < VT)) begin
                fails++;
                $display("FAIL invariant actual h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b required sync within blank and counts in range",
                         hcount, vcount, hsync, hblnk, vsync, vblnk);
            end

            if (rst_at_edge) begin
                hs_run = 0;
                vs_cnt = 0;
                fe_since_rst = 0;
                last_fe = -1;
                tests++;
                if (act_vec !== 29'd0) begin
                    fails++;
                    $display("FAIL reset_zero actual h=%0d v=%0d flags=%b required all zero", hcount, vcount, act_vec[4:0]);
                end
            end else if (since_rel >= 1 && since_rel <= 3) begin
                tests++;
                if (hcount !== 12'(since_rel) || vcount !== 12'd0 || act_vec[4:0] !== 5'd0) begin
                    fails++;
                    $display("FAIL release_seq actual h=%0d v=%0d flags=%b required h=%0d v=0 flags=00000",
                             hcount, vcount, act_vec[4:0], since_rel);
                end
            end

            if (hsync === 1'b1) begin
                hs_run++;
            end else begin
                if (hs_run != 0) begin
                    tests++;
                    if (hs_run != 5) begin
                        fails++;
                        $display("FAIL hsync_width actual %0d required 5", hs_run);
                    end
                end
                hs_run = 0;
            end

            if (vsync === 1'b1) vs_cnt++;

            if (frame_end === 1'b1) begin
                fe_since_rst++;
                tests++;
                if (vs_cnt != 90) begin
                    fails++;
                    $display("FAIL vsync_cycles actual %0d required 90", vs_cnt);
                end
                vs_cnt = 0;
                if (last_fe >= 0) begin
                    tests++;
                    if (cyc - last_fe != 630) begin
                        fails++;
                        $display("FAIL frame_period actual %0d required 630", cyc - last_fe);
                    end
                end
                last_fe = cyc;
            end

            if (end_req && !end_done) begin
                end_done = 1'b1;
                tests++;
                if (fe_since_rst != 3) begin
                    fails++;
                    $display("FAIL frame_end_count actual %0d required 3", fe_since_rst);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        repeat (5) @(negedge pclk);
        rst_n = 1'b1;

        // Release shows pos 0 here; 250 negedges later the display is (10,8).
        repeat (250) @(negedge pclk);
        rst_n = 1'b0;
        @(negedge pclk);
        rst_n = 1'b1;

        repeat (30) begin
            repeat ($urandom_range(1, 900)) @(negedge pclk);
            rst_n = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge pclk);
            rst_n = 1'b1;
        end

        rst_n = 1'b0;
        @(negedge pclk);
        rst_n = 1'b1;
        repeat (3 * 630 + 5) @(negedge pclk);
        end_req = 1'b1;
        repeat (2) @(negedge pclk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
